oh_absacc: RTL



---
 rtl/oh_absacc.sv | 139 +++++++++++++
 1 files changed

// File: rtl/oh_absacc.sv
// oh_absacc: streaming absolute-value accumulator with per-frame result and sticky flags.
// Define OH_ABSACC_SAT_EN to clamp the accumulator at 2^M-1 on overflow instead of wrapping.
`default_nettype none

module oh_absacc #(
   parameter int N = 32,
   parameter int M = 48,
   parameter int C = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] out,
   output logic [C-1:0] out_count,
   output logic         out_minneg,
   output logic         out_ovf
);

   logic         r_s1_valid;
   logic [N-1:0] r_s1_mag;
   logic         r_s1_last;
   logic         r_s1_minneg;

   logic [M-1:0] r_acc;
   logic [C-1:0] r_cnt;
   logic         r_minneg_s;
   logic         r_ovf_s;

   logic         r_out_valid;
   logic [M-1:0] r_out;
   logic [C-1:0] r_out_count;
   logic         r_out_minneg;
   logic         r_out_ovf;

   logic         w_stall;
   logic         w_s1_adv;
   logic         w_in_xfer;
   logic [N-1:0] w_mag;
   logic         w_minneg;
   logic [M:0]   w_sum;
   logic         w_carry;
   logic [M-1:0] w_acc_nxt;
   logic         w_cnt_full;
   logic [C-1:0] w_cnt_nxt;
   logic         w_minneg_nxt;
   logic         w_ovf_nxt;

   // Only a frame-ending sample that cannot hand off its result holds the pipe.
   assign w_stall   = r_s1_valid & r_s1_last & r_out_valid & ~out_ready;
   assign in_ready  = ~reset & ~w_stall;
   assign w_s1_adv  = r_s1_valid & ~w_stall;
   assign w_in_xfer = in_valid & in_ready;

   assign w_mag    = in[N-1] ? (~in + {{(N-1){1'b0}}, 1'b1}) : in;
   assign w_minneg = (in == {1'b1, {(N-1){1'b0}}});

   assign w_sum   = {1'b0, r_acc} + {{(M+1-N){1'b0}}, r_s1_mag};
   assign w_carry = w_sum[M];
`ifdef OH_ABSACC_SAT_EN
   assign w_acc_nxt = w_carry ? {M{1'b1}} : w_sum[M-1:0];
`else
   assign w_acc_nxt = w_sum[M-1:0];
`endif

   assign w_cnt_full   = &r_cnt;
   assign w_cnt_nxt    = w_cnt_full ? r_cnt : (r_cnt + {{(C-1){1'b0}}, 1'b1});
   assign w_minneg_nxt = r_minneg_s | r_s1_minneg;
   assign w_ovf_nxt    = r_ovf_s | w_carry | w_cnt_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_mag    <= '0;
         r_s1_last   <= 1'b0;
         r_s1_minneg <= 1'b0;
      end else if (w_in_xfer) begin
         r_s1_valid  <= 1'b1;
         r_s1_mag    <= w_mag;
         r_s1_last   <= in_last;
         r_s1_minneg <= w_minneg;
      end else if (w_s1_adv) begin
         r_s1_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc      <= '0;
         r_cnt      <= '0;
         r_minneg_s <= 1'b0;
         r_ovf_s    <= 1'b0;
      end else if (w_s1_adv) begin
         if (r_s1_last) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_minneg_s <= 1'b0;
            r_ovf_s    <= 1'b0;
         end else begin
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_minneg_s <= w_minneg_nxt;
            r_ovf_s    <= w_ovf_nxt;
         end
      end
   end

   // A new result may load in the same cycle the previous one is consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid  <= 1'b0;
         r_out        <= '0;
         r_out_count  <= '0;
         r_out_minneg <= 1'b0;
         r_out_ovf    <= 1'b0;
      end else if (w_s1_adv & r_s1_last) begin
         r_out_valid  <= 1'b1;
         r_out        <= w_acc_nxt;
         r_out_count  <= w_cnt_nxt;
         r_out_minneg <= w_minneg_nxt;
         r_out_ovf    <= w_ovf_nxt;
      end else if (out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out        = r_out;
   assign out_count  = r_out_count;
   assign out_minneg = r_out_minneg;
   assign out_ovf    = r_out_ovf;

endmodule

`default_nettype wire
